multiplier_2stage: RTL and testbench
====================================

Name: multiplier_2stage

Overview:
Two-stage pipelined integer multiplier: P = A × B, with a fixed latency of two clock cycles.
- Stage 1 registers the operands; stage 2 registers the product.
- Used as a DSP-slice-style building block in the SoC datapath, mapping onto one hard multiplier plus input and output registers.
- Pipelined: a new operand pair is accepted every cycle.

Parameters:
- WIDTH_A, 18, operand A width in bits (≥1).
- WIDTH_B, 18, operand B width in bits (≥1).
- WIDTH_P, 36, product output width in bits (≥1); nominally WIDTH_A+WIDTH_B.
- SIGNED, 0, 0 = unsigned operands/product; 1 = two's-complement operands/product.

Ports:
- clk  in  1  rising-edge clock; all registers are clocked on it.
- rst_n  in  1  asynchronous, active-high reset (asserted = 1) despite the legacy _n name; clears all pipeline registers.
- A  in  WIDTH_A  multiplicand.
- B  in  WIDTH_B  multiplier.
- P  out  WIDTH_P  registered product.

Behaviour:
- Registers: a_r[WIDTH_A], b_r[WIDTH_B] (stage 1) and p_r[WIDTH_P] (stage 2). P is driven directly by p_r; there is no combinational path from A/B to P.
- Reset:
  - While rst_n=1, a_r, b_r and p_r are all 0 immediately, without waiting for a clock edge, so P=0.
  - Reset asserted mid-operation discards all in-flight products.
- Normal operation, each rising edge with rst_n=0:
  - a_r<=A and b_r<=B.
  - p_r<=a_r×b_r, resized to WIDTH_P.
- Latency: operands present at rising edge N appear on P after rising edge N+1. Throughput is one product per cycle.
- After reset deasserts:
  - The first edge loads operands.
  - P shows the first real product after the second edge.
  - Until then P=0 (0×0).
- Full product width is WIDTH_A+WIDTH_B.
  - If WIDTH_P < full width: keep the low WIDTH_P bits (truncation, no saturation).
  - If WIDTH_P > full width: zero-extend when SIGNED=0, sign-extend when SIGNED=1.
- SIGNED=1: A, B and P are interpreted as two's complement; the most negative × most negative case is exact at full width.
- No X-propagation: outputs are deterministic from reset onward.
- Operand changes between clock edges have no effect until the next rising edge.

Optional Feature:
- Macro: MULT2_VALID_EN.
- When defined:
  - Adds input port in_valid (1 bit) and output port out_valid (1 bit).
  - out_valid is in_valid delayed by two cycles through a 2-bit shift register, reset to 0.
  - The stage-1 operand registers load only when in_valid=1; otherwise they hold.
  - P updates every cycle from the held stage-1 values.
- When undefined:
  - No extra ports.
  - Stage-1 registers load every cycle; behaviour exactly as above.

Test Plan:
- Reset: hold rst_n=1 with A=B=0, clock running → P=0 throughout. Assert rst_n asynchronously between edges while P≠0 → P=0 immediately.
- Basic pipeline, defaults:
  - Stimulus: after reset release, drive A=10,B=20; then 123,45; then 300,300; then 500,2; each applied at a falling edge, one cycle apart.
  - Required P, one cycle apart, starting two rising edges after the first pair is applied: 200, 5535, 90000, 1000.
  - After stimulus stops, inputs held at 500,2 → P holds at 1000.
- Max unsigned: A=B=2^18−1 → P=68718952449 (0xFFFF80001) exactly two edges later.
- Truncation: WIDTH_P=16, A=300, B=300 → P=90000 mod 65536 = 24464.
- Signed: SIGNED=1, A=−3, B=7 → P=−21. A=B=−2^17 → P=2^34.
- Valid, with MULT2_VALID_EN:
  - in_valid=1 for one cycle with A=6,B=7 → out_valid=1 for exactly one cycle, two edges later, with P=42.
  - Subsequent in_valid=0 cycles hold P=42 with out_valid=0.

Source files
------------

// File: rtl/multiplier_2stage.sv
// ============================================================================
// Module      : multiplier_2stage
// Description : Two-stage pipelined integer multiplier (operand regs -> product reg).
//               Optional valid handshake enabled by defining MULT2_VALID_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multiplier_2stage #(
    parameter int WIDTH_A = 18,
    parameter int WIDTH_B = 18,
    parameter int WIDTH_P = 36,
    parameter int SIGNED  = 0
) (
    input  logic               clk,
    input  logic               rst_n,
`ifdef MULT2_VALID_EN
    input  logic               in_valid,
    output logic               out_valid,
`endif
    input  logic [WIDTH_A-1:0] A,
    input  logic [WIDTH_B-1:0] B,
    output logic [WIDTH_P-1:0] P
);

    localparam int FW = WIDTH_A + WIDTH_B;
    localparam int XW = (WIDTH_P > FW) ? WIDTH_P : FW;

    logic [WIDTH_A-1:0] r_a;
    logic [WIDTH_B-1:0] r_b;
    logic [WIDTH_P-1:0] r_p;
    logic [XW-1:0]      w_a_x;
    logic [XW-1:0]      w_b_x;
    logic [XW-1:0]      w_prod;
    logic               w_ld;

    // Extending operands to the result width before multiplying yields the
    // correctly sign/zero-extended product directly, even when XW > FW.
    generate
        if (SIGNED != 0) begin : g_signed
            assign w_a_x = {{(XW-WIDTH_A){r_a[WIDTH_A-1]}}, r_a};
            assign w_b_x = {{(XW-WIDTH_B){r_b[WIDTH_B-1]}}, r_b};
        end else begin : g_unsigned
            assign w_a_x = {{(XW-WIDTH_A){1'b0}}, r_a};
            assign w_b_x = {{(XW-WIDTH_B){1'b0}}, r_b};
        end
    endgenerate

    assign w_prod = w_a_x * w_b_x;

    generate
        if (XW > WIDTH_P) begin : g_trunc
            logic w_unused_hi;
            assign w_unused_hi = ^w_prod[XW-1:WIDTH_P];
        end
    endgenerate

`ifdef MULT2_VALID_EN
    logic [1:0] r_vld;

    assign w_ld      = in_valid;
    assign out_valid = r_vld[1];

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_vld <= 2'b00;
        end else begin
            r_vld <= {r_vld[0], in_valid};
        end
    end
`else
    assign w_ld = 1'b1;
`endif

    // rst_n is active-high despite its name.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_a <= '0;
            r_b <= '0;
            r_p <= '0;
        end else begin
            if (w_ld) begin
                r_a <= A;
                r_b <= B;
            end
            r_p <= w_prod[WIDTH_P-1:0];
        end
    end

    assign P = r_p;

endmodule

`default_nettype wire

// File: tb/tb_multiplier_2stage.sv
// Self-checking bench for multiplier_2stage: four parameterisations share stimulus.
`default_nettype none

module tb_multiplier_2stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [17:0] A, B;
    logic        in_v;
    logic [35:0] P_def;
    logic [15:0] P_trn;
    logic [35:0] P_sgn;
    logic [19:0] P_sx;

    int n_assert = 0;
    int n_fail   = 0;

    logic [17:0] ha, hb;
    logic [35:0] hist[$];
    bit          vh[$];

`ifdef MULT2_VALID_EN
    localparam bit VEN = 1'b1;
    logic ov_def, ov_trn, ov_sgn, ov_sx;
`else
    localparam bit VEN = 1'b0;
`endif

    always #5 clk = ~clk;

    multiplier_2stage u_def (
        .clk(clk), .rst_n(rst_n),
`ifdef MULT2_VALID_EN
        .in_valid(in_v), .out_valid(ov_def),
`endif
        .A(A), .B(B), .P(P_def)
    );

    multiplier_2stage #(.WIDTH_P(16)) u_trn (
        .clk(clk), .rst_n(rst_n),
`ifdef MULT2_VALID_EN
        .in_valid(in_v), .out_valid(ov_trn),
`endif
        .A(A), .B(B), .P(P_trn)
    );

    multiplier_2stage #(.SIGNED(1)) u_sgn (
        .clk(clk), .rst_n(rst_n),
`ifdef MULT2_VALID_EN
        .in_valid(in_v), .out_valid(ov_sgn),
`endif
        .A(A), .B(B), .P(P_sgn)
    );

    multiplier_2stage #(.WIDTH_A(8), .WIDTH_B(8), .WIDTH_P(20), .SIGNED(1)) u_sx (
        .clk(clk), .rst_n(rst_n),
`ifdef MULT2_VALID_EN
        .in_valid(in_v), .out_valid(ov_sx),
`endif
        .A(A[7:0]), .B(B[7:0]), .P(P_sx)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_def"}, {28'd0, P_def}, 64'd0);
        check({tag, "_trn"}, {48'd0, P_trn}, 64'd0);
        check({tag, "_sgn"}, {28'd0, P_sgn}, 64'd0);
        check({tag, "_sx"},  {44'd0, P_sx},  64'd0);
`ifdef MULT2_VALID_EN
        check({tag, "_ov"}, {63'd0, ov_def}, 64'd0);
`endif
    endtask

    // Reference: P after edge k is the product of the operand pair captured at edge k-1.
    task automatic check_all();
        logic [17:0] a, b;
        logic [7:0]  a8, b8;
        bit          v;
        longint      ua, ub, sa, sb, sa8, sb8;
        if (hist.size() >= 2) begin
            {a, b} = hist[hist.size()-2];
            v      = vh[vh.size()-2];
        end else begin
            a = '0; b = '0; v = 1'b0;
        end
        a8  = a[7:0];
        b8  = b[7:0];
        ua  = longint'(a);
        ub  = longint'(b);
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        sa8 = longint'($signed(a8));
        sb8 = longint'($signed(b8));
        check("p_unsigned", {28'd0, P_def}, 64'(ua * ub) & 64'hF_FFFF_FFFF);
        check("p_trunc16",  {48'd0, P_trn}, 64'((ua * ub) % 65536));
        check("p_signed",   {28'd0, P_sgn}, 64'(sa * sb) & 64'hF_FFFF_FFFF);
        check("p_sext20",   {44'd0, P_sx},  64'(sa8 * sb8) & 64'hF_FFFF);
`ifdef MULT2_VALID_EN
        check("out_valid", {63'd0, ov_def}, {63'd0, v});
`else
        if (v) ; // handshake absent in this build
`endif
    endtask

    task automatic tick(input logic [17:0] a, input logic [17:0] b, input bit v);
        @(negedge clk);
        A    = a;
        B    = b;
        in_v = v;
        @(posedge clk);
        if (!VEN || v) begin
            ha = a;
            hb = b;
        end
        hist.push_back({ha, hb});
        vh.push_back(v);
        #1 check_all();
    endtask

    task automatic clear_model();
        hist.delete();
        vh.delete();
        ha = '0;
        hb = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b1;
        A = '0; B = '0; in_v = 1'b0;
        clear_model();

        repeat (3) begin
            @(posedge clk);
            #1 check_zero("reset_hold");
        end
        rst_n = 1'b0;

        tick(18'd10,  18'd20,  1'b1);
        tick(18'd123, 18'd45,  1'b1); check("dir_200",   {28'd0, P_def}, 64'd200);
        tick(18'd300, 18'd300, 1'b1); check("dir_5535",  {28'd0, P_def}, 64'd5535);
        tick(18'd500, 18'd2,   1'b1); check("dir_90000", {28'd0, P_def}, 64'd90000);
        tick(18'd500, 18'd2,   1'b1); check("dir_1000",  {28'd0, P_def}, 64'd1000);
        tick(18'd500, 18'd2,   1'b1); check("hold_1000", {28'd0, P_def}, 64'd1000);

        tick(18'h3FFFF, 18'h3FFFF, 1'b1);
        tick(18'd0, 18'd0, 1'b1);     check("max_unsigned", {28'd0, P_def}, 64'hF_FFF8_0001);

        tick(18'd300, 18'd300, 1'b1);
        tick(18'd0, 18'd0, 1'b1);     check("trunc_24464", {48'd0, P_trn}, 64'd24464);

        tick(18'h3FFFD, 18'd7, 1'b1);
        tick(18'h20000, 18'h20000, 1'b1);
        check("signed_m21",   {28'd0, P_sgn}, 64'hF_FFFF_FFEB);
        check("sext20_m21",   {44'd0, P_sx},  64'hF_FFEB);
        tick(18'd0, 18'd0, 1'b1);
        check("signed_2p34",  {28'd0, P_sgn}, 64'h4_0000_0000);

        repeat (40) tick(18'($urandom), 18'($urandom), 1'b1);

        tick(18'd1000, 18'd1000, 1'b1);
        tick(18'd1000, 18'd1000, 1'b1);
        check("pre_reset_nz", {28'd0, P_def}, 64'd1000000);
        @(negedge clk);
        #2 rst_n = 1'b1;
        #1 check_zero("async_reset");
        @(posedge clk);
        #1 check_zero("reset_mid");
        rst_n = 1'b0;
        clear_model();

        tick(18'd4, 18'd5, 1'b1);
        tick(18'd0, 18'd0, 1'b1);     check("post_reset_20", {28'd0, P_def}, 64'd20);

        if (VEN) begin
            tick(18'd9, 18'd9, 1'b0);
            tick(18'd6, 18'd7, 1'b1);
            tick(18'd111, 18'd222, 1'b0);
            check("valid_p42", {28'd0, P_def}, 64'd42);
            tick(18'd111, 18'd222, 1'b0);
            check("valid_hold_42", {28'd0, P_def}, 64'd42);
            tick(18'd13, 18'd17, 1'b0);
            check("valid_hold_42b", {28'd0, P_def}, 64'd42);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
